// File: rtl/warp_rr_arbiter.sv
// Round-robin arbiter merging NUM_REQ ready/valid requesters onto one registered
// output channel; a requester holds the grant until its last beat is accepted.
module warp_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 64,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  output logic [NUM_REQ-1:0]       o_req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]       i_req_last,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [WIDTH-1:0]         o_out_data,
  output logic                     o_out_last,
  output logic [ID_WIDTH-1:0]      o_out_id
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [ID_WIDTH:0]   NUM_REQ_EXT = (ID_WIDTH+1)'(NUM_REQ);
  localparam logic [ID_WIDTH-1:0] LAST_IDX    = ID_WIDTH'(NUM_REQ - 1);

  state_t              state_reg, state_next;
  logic [ID_WIDTH-1:0] ptr_reg, ptr_next;
  logic [ID_WIDTH-1:0] owner_reg, owner_next;

  logic                out_valid_reg;
  logic [WIDTH-1:0]    out_data_reg;
  logic                out_last_reg;
  logic [ID_WIDTH-1:0] out_id_reg;

  logic [WIDTH-1:0]    req_data_arr [NUM_REQ];
  logic                cand_found;
  logic [ID_WIDTH-1:0] cand_idx;
  logic [ID_WIDTH:0]   scan_idx;
  logic                can_load;
  logic                grant_valid;
  logic [ID_WIDTH-1:0] grant_idx;
  logic                grant_last;
  logic                accept;

  // Increment that wraps at NUM_REQ-1 so non-power-of-two counts stay in range.
  function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_data_arr[gi] = i_req_data[gi*WIDTH +: WIDTH];
    assign o_req_ready[gi]  = accept && (grant_idx == ID_WIDTH'(gi));
  end

  // First valid requester scanning ptr, ptr+1, ... with wrap at NUM_REQ.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    scan_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = {1'b0, ptr_reg} + (ID_WIDTH+1)'(i);
      if (scan_idx >= NUM_REQ_EXT) begin
        scan_idx = scan_idx - NUM_REQ_EXT;
      end
      if (!cand_found && i_req_valid[scan_idx[ID_WIDTH-1:0]]) begin
        cand_found = 1'b1;
        cand_idx   = scan_idx[ID_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    if (state_reg == IDLE) begin
      if (accept) begin
        if (grant_last) begin
          ptr_next = wrap_inc(grant_idx);
        end else begin
          state_next = LOCKED;
          owner_next = grant_idx;
        end
      end
    end else if (accept && grant_last) begin
      state_next = IDLE;
      ptr_next   = wrap_inc(owner_reg);
    end
  end

  // While locked only the owner may win, even if it is momentarily idle.
  always_comb begin
    can_load = !out_valid_reg || i_out_ready;
    if (state_reg == IDLE) begin
      grant_idx   = cand_idx;
      grant_valid = cand_found;
    end else begin
      grant_idx   = owner_reg;
      grant_valid = i_req_valid[owner_reg];
    end
    grant_last = i_req_last[grant_idx];
    accept     = grant_valid && can_load;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_id_reg    <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= req_data_arr[grant_idx];
      out_last_reg  <= grant_last;
      out_id_reg    <= grant_idx;
    end else if (i_out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign o_out_valid = out_valid_reg;
  assign o_out_data  = out_data_reg;
  assign o_out_last  = out_last_reg;
  assign o_out_id    = out_id_reg;

`ifdef WARP_FORMAL
  a_ready_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0(o_req_ready));
  a_ready_valid: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (o_req_ready & ~i_req_valid) == '0);
  a_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (o_out_valid && !i_out_ready) |=> (o_out_valid && $stable(o_out_data)
      && $stable(o_out_last) && $stable(o_out_id)));
  a_ptr_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    ({1'b0, ptr_reg} < NUM_REQ_EXT) && ({1'b0, owner_reg} < NUM_REQ_EXT));
  c_lock: cover property (@(posedge i_clk) state_reg == IDLE && state_next == LOCKED);
  c_unlock: cover property (@(posedge i_clk) state_reg == LOCKED && state_next == IDLE);
  c_wrap: cover property (@(posedge i_clk) ptr_reg == LAST_IDX && ptr_next == '0 && accept);
`endif

endmodule

// File: tb/tb_warp_rr_arbiter.sv
// Bench for warp_rr_arbiter: a per-cycle reference model of the round-robin/burst rules
// checks a 4-requester instance; directed literal checks pin the model and a 3-requester instance.
module tb_warp_rr_arbiter;
  localparam int W = 32;

  logic           clk;
  logic           rst_n;
  logic [3:0]     req_valid;
  logic [3:0]     req_ready;
  logic [4*W-1:0] req_data;
  logic [3:0]     req_last;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [1:0]     out_id;

  logic           rst3_n;
  logic [2:0]     v3;
  logic [2:0]     rdy3;
  logic [3*W-1:0] d3;
  logic [2:0]     l3;
  logic           ov3;
  logic           or3;
  logic [W-1:0]   od3;
  logic           ol3;
  logic [1:0]     oid3;

  int n_vec  = 0;
  int n_fail = 0;

  warp_rr_arbiter #(.NUM_REQ(4), .WIDTH(W)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_data(req_data), .i_req_last(req_last),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_out_last(out_last), .o_out_id(out_id)
  );

  warp_rr_arbiter #(.NUM_REQ(3), .WIDTH(W)) dut3 (
    .i_clk(clk), .i_rst_n(rst3_n),
    .i_req_valid(v3), .o_req_ready(rdy3),
    .i_req_data(d3), .i_req_last(l3),
    .o_out_valid(ov3), .i_out_ready(or3),
    .o_out_data(od3), .o_out_last(ol3), .o_out_id(oid3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int k, input logic v, input logic [W-1:0] d, input logic l);
    req_valid[k]         = v;
    req_data[k*W +: W]   = d;
    req_last[k]          = l;
  endtask

  // Reference model: owner < 0 means no burst in progress.
  int           m_ptr, m_owner, m_id, cand, mk;
  logic         m_valid, m_last, m_can_load;
  logic [W-1:0] m_data;
  logic [3:0]   exp_ready;
  logic [3:0]   acc_mask;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      m_ptr = 0; m_owner = -1; m_valid = 1'b0; m_data = '0; m_last = 1'b0; m_id = 0;
      acc_mask = '0;
    end else begin
      m_can_load = !m_valid || out_ready;
      cand = -1;
      if (m_owner < 0) begin
        for (int j = 0; j < 4; j++) begin
          mk = (m_ptr + j) % 4;
          if (cand < 0 && req_valid[mk]) cand = mk;
        end
      end else if (req_valid[m_owner]) begin
        cand = m_owner;
      end
      exp_ready = '0;
      if (cand >= 0 && m_can_load) exp_ready[cand] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
        chk("out_data", 64'(out_data), 64'(m_data));
        chk("out_last", 64'(out_last), 64'(m_last));
        chk("out_id", 64'(out_id), 64'(m_id));
        if (out_ready) $display("beat id=%0d data=%08h last=%0d", out_id, out_data, out_last);
      end
      acc_mask = req_valid & req_ready;
      if (cand >= 0 && m_can_load) begin
        m_valid = 1'b1;
        m_data  = req_data[cand*W +: W];
        m_last  = req_last[cand];
        m_id    = cand;
        if (m_owner < 0) begin
          if (m_last) m_ptr = (cand + 1) % 4;
          else        m_owner = cand;
        end else if (m_last) begin
          m_ptr   = (m_owner + 1) % 4;
          m_owner = -1;
        end
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  int seq4 [6] = '{0, 1, 2, 3, 0, 1};
  int seq3 [5] = '{0, 1, 2, 0, 1};
  int left [4];

  initial begin
    rst_n = 1'b0; rst3_n = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0; out_ready = 1'b1;
    v3 = '0; d3 = '0; l3 = '0; or3 = 1'b1;

    // Reset with no requests
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
    end
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_id", 64'(out_id), 64'd0);
    @(negedge clk); rst_n = 1'b1; rst3_n = 1'b1;

    // All four valid, single-beat: ids rotate 0,1,2,3,0,1
    @(negedge clk);
    for (int k = 0; k < 4; k++) set_req(k, 1'b1, W'(32'h1000 + k), 1'b1);
    #1; chk("rr_first_ready", 64'(req_ready), 64'b0001);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) req_valid = '0;
      #1;
      chk("rr_id", 64'(out_id), 64'(seq4[i]));
      chk("rr_data", 64'(out_data), 64'(32'h1000 + seq4[i]));
    end

    // Requester 2 three-beat burst with everyone valid; then 3, then 0
    @(negedge clk);
    for (int k = 0; k < 4; k++) set_req(k, 1'b1, W'(32'h1000 + k), 1'b1);
    set_req(2, 1'b1, 32'h2000, 1'b0);
    #1; chk("burst_ready0", 64'(req_ready), 64'b0100);
    @(negedge clk); set_req(2, 1'b1, 32'h2001, 1'b0); #1;
    chk("burst_id1", 64'(out_id), 64'd2); chk("burst_data1", 64'(out_data), 64'h2000);
    chk("burst_last1", 64'(out_last), 64'd0);
    @(negedge clk); set_req(2, 1'b1, 32'h2002, 1'b1); #1;
    chk("burst_id2", 64'(out_id), 64'd2); chk("burst_data2", 64'(out_data), 64'h2001);
    @(negedge clk); #1;
    chk("burst_id3", 64'(out_id), 64'd2); chk("burst_last3", 64'(out_last), 64'd1);
    chk("burst_next_ready", 64'(req_ready), 64'b1000);
    @(negedge clk); #1;
    chk("after_burst_id", 64'(out_id), 64'd3);
    @(negedge clk); req_valid = '0; #1;
    chk("after_burst_id2", 64'(out_id), 64'd0);

    // Owner 1 drops valid for two cycles mid-burst while 0 is waiting
    @(negedge clk);
    set_req(0, 1'b1, 32'h1000, 1'b1);
    set_req(1, 1'b1, 32'h3000, 1'b0);
    #1; chk("drop_ready0", 64'(req_ready), 64'b0010);
    @(negedge clk); req_valid[1] = 1'b0; #1;
    chk("drop_beat1_id", 64'(out_id), 64'd1);
    chk("drop_locked_ready", 64'(req_ready), 64'd0);
    @(negedge clk); #1;
    chk("drop_bubble1", 64'(out_valid), 64'd0);
    chk("drop_locked_ready2", 64'(req_ready), 64'd0);
    @(negedge clk); set_req(1, 1'b1, 32'h3001, 1'b1); #1;
    chk("drop_bubble2", 64'(out_valid), 64'd0);
    chk("drop_resume_ready", 64'(req_ready), 64'b0010);
    @(negedge clk); req_valid = '0; #1;
    chk("drop_end_id", 64'(out_id), 64'd1); chk("drop_end_data", 64'(out_data), 64'h3001);

    // Backpressure with 0xA5 from requester 3 held for five cycles
    @(negedge clk); set_req(3, 1'b1, 32'hA5, 1'b1); #1;
    chk("bp_ready0", 64'(req_ready), 64'b1000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      set_req(0, 1'b1, 32'h1000, 1'b1);
      set_req(3, 1'b1, 32'hB6, 1'b1);
      #1;
      chk("bp_data", 64'(out_data), 64'hA5);
      chk("bp_id", 64'(out_id), 64'd3);
      chk("bp_ready", 64'(req_ready), 64'd0);
    end
    @(negedge clk); out_ready = 1'b1; #1;
    chk("bp_release_ready", 64'(req_ready), 64'b0001);
    @(negedge clk); req_valid = '0; #1;
    chk("bp_next_id", 64'(out_id), 64'd0);
    @(negedge clk);

    // Random traffic obeying the requester protocol
    for (int k = 0; k < 4; k++) left[k] = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (acc_mask[k]) begin
          req_valid[k] = 1'b0;
          left[k]--;
        end
        if (!req_valid[k] && $urandom_range(0, 2) != 0) begin
          if (left[k] == 0) left[k] = $urandom_range(1, 4);
          set_req(k, 1'b1, W'($urandom), left[k] == 1);
        end
      end
      out_ready = $urandom_range(0, 3) != 0;
    end
    @(negedge clk); req_valid = '0; out_ready = 1'b1;

    // Three requesters: rotation wraps from 2 back to 0
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      v3[k] = 1'b1; d3[k*W +: W] = W'(32'h500 + k); l3[k] = 1'b1;
    end
    #1; chk("n3_ready0", 64'(rdy3), 64'b001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) v3 = '0;
      #1;
      chk("n3_id", 64'(oid3), 64'(seq3[i]));
      chk("n3_data", 64'(od3), 64'(32'h500 + seq3[i]));
    end

    // Reset mid-burst of requester 2 while backpressured
    @(negedge clk);
    v3 = 3'b100; d3[2*W +: W] = 32'h77; l3[2] = 1'b0;
    #1; chk("n3_burst_ready", 64'(rdy3), 64'b100);
    @(negedge clk); d3[2*W +: W] = 32'h78; or3 = 1'b0; #1;
    chk("n3_burst_id", 64'(oid3), 64'd2); chk("n3_burst_valid", 64'(ov3), 64'd1);
    chk("n3_bp_ready", 64'(rdy3), 64'd0);
    #2; rst3_n = 1'b0; #1;
    chk("n3_async_valid", 64'(ov3), 64'd0);
    chk("n3_async_id", 64'(oid3), 64'd0);
    chk("n3_async_data", 64'(od3), 64'd0);
    @(negedge clk);
    v3 = 3'b101; d3[0 +: W] = 32'h55; l3[0] = 1'b1; or3 = 1'b1;
    #1; chk("n3_rst_valid", 64'(ov3), 64'd0);
    @(negedge clk); rst3_n = 1'b1; #1;
    chk("n3_post_rst_ready", 64'(rdy3), 64'b001);
    @(negedge clk); v3 = '0; #1;
    chk("n3_post_rst_id", 64'(oid3), 64'd0);
    chk("n3_post_rst_data", 64'(od3), 64'h55);
    chk("n3_post_rst_valid", 64'(ov3), 64'd1);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
